// File: rtl/bcd_tick_sequencer.sv
// Serial multi-digit BCD up/down counter built around one shared digit tick unit.
// Optional BCD_TICK_SEQ_SATURATE_EN: a step that would wrap instead pulses done+wrap and holds count.
module bcd_tick (
  input  logic [3:0] d,
  input  logic       up,
  output logic [3:0] q
);
  always_comb begin
    if (up) q = (d == 4'd9) ? 4'd0 : d + 4'd1;
    else    q = (d == 4'd0) ? 4'd9 : d - 4'd1;
  end
endmodule

module bcd_tick_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic                cmd_dir,
  output logic                cmd_ready,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                wrap
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STEP = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] idx;
  logic          dir;
  logic [W-1:0]  cnt;
  logic [3:0]    cur;
  logic [3:0]    nxt;
  logic          cont;
  logic          last;
  logic [W-1:0]  lval;

  assign cur       = cnt[4*idx +: 4];
  assign cont      = dir ? (cur == 4'd9) : (cur == 4'd0);
  assign last      = (idx == IW'(DIGITS - 1));
  assign count     = cnt;
  assign busy      = (state == STEP);
  assign cmd_ready = (state == IDLE) & ~load;

  bcd_tick u_tick (
    .d  (cur),
    .up (dir),
    .q  (nxt)
  );

  // Out-of-range load digits are cleared so the tick unit only sees 0..9.
  always_comb begin
    lval = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] <= 4'd9)
        lval[4*i +: 4] = load_val[4*i +: 4];
    end
  end

`ifdef BCD_TICK_SEQ_SATURATE_EN
  logic all9;
  logic all0;
  logic sat;

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (cnt[4*i +: 4] != 4'd0) all0 = 1'b0;
    end
  end

  assign sat = cmd_dir ? all9 : all0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      dir   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (load) begin
            cnt <= lval;
          end else if (cmd_valid) begin
            dir <= cmd_dir;
            idx <= '0;
`ifdef BCD_TICK_SEQ_SATURATE_EN
            if (sat) begin
              done <= 1'b1;
              wrap <= 1'b1;
            end else begin
              state <= STEP;
            end
`else
            state <= STEP;
`endif
          end
        end
        (state == STEP): begin
          cnt[4*idx +: 4] <= nxt;
          if (cont && !last) begin
            idx <= idx + IW'(1);
          end else begin
            state <= IDLE;
            done  <= 1'b1;
            wrap  <= cont;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_tick_sequencer.sv
// Scoreboard bench for bcd_tick_sequencer (DIGITS=4).
// Driver queues expected {count,wrap}; a negedge monitor checks each done pulse.
module tb_bcd_tick_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_dir;
  logic        cmd_ready;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        wrap;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb[$];

  bcd_tick_sequencer #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("sb_count", {16'h0, count}, {16'h0, e[16:1]});
        chk("sb_wrap", {31'h0, wrap}, {31'h0, e[0]});
        chk("sb_ready", {31'h0, cmd_ready}, {31'h0, ~load});
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [15:0] exp);
    @(negedge clk);
    load = 1'b1;
    load_val = v;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk("load_count", {16'h0, count}, {16'h0, exp});
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int lat;
    int bc;
    lat = 1;
    bc = 0;
    while (!done && lat < 50) begin
      if (busy) bc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, bc, exp_lat - 1);
  endtask

  task automatic do_cmd(input logic d, input logic [15:0] ec, input logic ew,
                        input int exp_lat, input string tag);
    int n;
    sb.push_back({ec, ew});
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'h0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(exp_lat, tag);
  endtask

  initial begin
    int acc;
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    load = 1'b0;
    load_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", {16'h0, count}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_ready", {31'h0, cmd_ready}, 32'd1);

    do_cmd(1'b1, 16'h0001, 1'b0, 2, "inc0");
    do_cmd(1'b0, 16'h0000, 1'b0, 2, "dec1");

    do_load(16'h0999, 16'h0999);
    do_cmd(1'b1, 16'h1000, 1'b0, 5, "carry");
    do_cmd(1'b0, 16'h0999, 1'b0, 5, "borrow");

    do_load(16'h9999, 16'h9999);
`ifdef BCD_TICK_SEQ_SATURATE_EN
    do_cmd(1'b1, 16'h9999, 1'b1, 1, "sat_hi");
    do_load(16'h0000, 16'h0000);
    do_cmd(1'b0, 16'h0000, 1'b1, 1, "sat_lo");
`else
    do_cmd(1'b1, 16'h0000, 1'b1, 5, "wrap_hi");
    do_load(16'h0000, 16'h0000);
    do_cmd(1'b0, 16'h9999, 1'b1, 5, "wrap_lo");
`endif

    // Held cmd_valid over a 4-digit walk, plus a load issued while busy.
    do_load(16'h0999, 16'h0999);
    sb.push_back({16'h1000, 1'b0});
    sb.push_back({16'h1001, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("held_accepts", acc, 2);
    chk("busy_after_second", {31'h0, busy}, 32'd1);
    load = 1'b1;
    load_val = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("busy_load_ignored", {16'h0, count}, 32'h1001);

    // load and cmd_valid together: load wins, no step.
    @(negedge clk);
    load = 1'b1;
    load_val = 16'h1234;
    cmd_valid = 1'b1;
    cmd_dir = 1'b1;
    #1;
    chk("conflict_ready", {31'h0, cmd_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    cmd_valid = 1'b0;
    chk("conflict_count", {16'h0, count}, 32'h1234);
    chk("conflict_busy", {31'h0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    do_load(16'h12F4, 16'h1204);

    // Reset during the second STEP of 0999 +1.
    do_load(16'h0999, 16'h0999);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", {16'h0, count}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_done", {31'h0, done}, 32'd0);
    chk("midrst_ready", {31'h0, cmd_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("midrst_hold", {16'h0, count}, 32'h0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
